// File: rtl/pic_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : pic_cycle_controller
// Purpose  : Q1..Q4 instruction-cycle sequencer and strobe decoder for the core
// Revision : 1.0 - initial release
// ============================================================================
module pic_cycle_controller #(
    parameter int PC_WIDTH     = 12,
    parameter int RESET_VECTOR = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [13:0]         instr,
    input  logic                alu_zero,
    input  logic                f_bit,
    input  logic [PC_WIDTH-1:0] stack_top,
    input  logic                wake,
    output logic [1:0]          phase,
    output logic                fetch_en,
    output logic                pc_inc,
    output logic                pc_load,
    output logic [PC_WIDTH-1:0] pc_target,
    output logic [1:0]          alu_type,
    output logic [3:0]          alu_op,
    output logic                use_literal,
    output logic                alu_start,
    output logic                w_we,
    output logic                f_we,
    output logic [6:0]          f_addr,
    output logic                push,
    output logic                pop,
    output logic                sleeping
);

    typedef enum logic [2:0] {
        RUN_Q1 = 3'd0,
        RUN_Q2 = 3'd1,
        RUN_Q3 = 3'd2,
        RUN_Q4 = 3'd3,
        SLEEP  = 3'd4
    } state_t;

    localparam logic [PC_WIDTH-1:0] c_reset_pc = PC_WIDTH'(RESET_VECTOR);

    state_t r_state;
    state_t w_next_state;
    logic   r_flush;
    logic   r_skip;

    logic                w_dec_w;
    logic                w_dec_f;
    logic                w_dec_push;
    logic                w_dec_pop;
    logic                w_dec_load;
    logic                w_dec_skip;
    logic                w_dec_sleep;
    logic [PC_WIDTH-1:0] w_dec_target;

    assign alu_type    = instr[13:12];
    assign alu_op      = instr[11:8];
    assign f_addr      = instr[6:0];
    assign use_literal = (instr[13:12] == 2'b11);

    // Instruction decode; w_dec_skip is only meaningful while in Q3.
    always_comb begin
        w_dec_w      = 1'b0;
        w_dec_f      = 1'b0;
        w_dec_push   = 1'b0;
        w_dec_pop    = 1'b0;
        w_dec_load   = 1'b0;
        w_dec_skip   = 1'b0;
        w_dec_sleep  = 1'b0;
        w_dec_target = c_reset_pc;
        case (instr[13:12])
            2'b00: begin
                if (instr[11:8] == 4'b0000) begin
                    if (instr[7]) begin
                        w_dec_f = 1'b1;
                    end else if (instr == 14'h0008) begin
                        w_dec_pop    = 1'b1;
                        w_dec_load   = 1'b1;
                        w_dec_target = stack_top;
                    end else if (instr == 14'h0063) begin
                        w_dec_sleep = 1'b1;
                    end
                end else begin
                    w_dec_w = ~instr[7];
                    w_dec_f = instr[7];
                    if (instr[11:8] == 4'b1011 || instr[11:8] == 4'b1111) begin
                        w_dec_skip = alu_zero;
                    end
                end
            end
            2'b01: begin
                case (instr[11:10])
                    2'b10:   w_dec_skip = ~f_bit;
                    2'b11:   w_dec_skip = f_bit;
                    default: w_dec_f    = 1'b1;
                endcase
            end
            2'b10: begin
                w_dec_load   = 1'b1;
                w_dec_push   = ~instr[11];
                w_dec_target = PC_WIDTH'(instr[10:0]);
            end
            default: begin
                w_dec_w = 1'b1;
                if (instr[11:10] == 2'b01) begin
                    w_dec_pop    = 1'b1;
                    w_dec_load   = 1'b1;
                    w_dec_target = stack_top;
                end
            end
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN_Q1:  w_next_state = RUN_Q2;
            RUN_Q2:  w_next_state = RUN_Q3;
            RUN_Q3:  w_next_state = RUN_Q4;
            RUN_Q4:  w_next_state = (w_dec_sleep && !r_flush) ? SLEEP : RUN_Q1;
            SLEEP:   w_next_state = wake ? RUN_Q1 : SLEEP;
            default: w_next_state = RUN_Q1;
        endcase
    end

    // Strobes are masked by reset so an abort never leaks a partial write.
    always_comb begin
        phase     = 2'd0;
        pc_inc    = 1'b0;
        alu_start = 1'b0;
        fetch_en  = 1'b0;
        w_we      = 1'b0;
        f_we      = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        pc_load   = 1'b0;
        pc_target = c_reset_pc;
        sleeping  = 1'b0;
        if (!reset) begin
            sleeping = (r_state == SLEEP);
            if (!r_flush) begin
                pc_target = w_dec_target;
            end
            case (r_state)
                RUN_Q1: begin
                    phase  = 2'd0;
                    pc_inc = 1'b1;
                end
                RUN_Q2: begin
                    phase     = 2'd1;
                    alu_start = 1'b1;
                end
                RUN_Q3: phase = 2'd2;
                RUN_Q4: begin
                    phase    = 2'd3;
                    fetch_en = 1'b1;
                    if (!r_flush) begin
                        w_we    = w_dec_w;
                        f_we    = w_dec_f;
                        push    = w_dec_push;
                        pop     = w_dec_pop;
                        pc_load = w_dec_load;
                    end
                end
                default: phase = 2'd0;
            endcase
        end
    end

    // The word fetched alongside a pc_load is stale, so a branch or taken skip flushes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN_Q1;
            r_flush <= 1'b1;
            r_skip  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == RUN_Q3) begin
                r_skip <= w_dec_skip;
            end
            if (r_state == RUN_Q4) begin
                r_flush <= !r_flush && (r_skip || w_dec_load);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pic_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pic_cycle_controller
// Purpose  : Directed self-checking bench for pic_cycle_controller
// Revision : 1.0 - initial release
// ============================================================================
module tb_pic_cycle_controller;

    logic        clk;
    logic        reset;
    logic [13:0] instr;
    logic        alu_zero;
    logic        f_bit;
    logic [11:0] stack_top;
    logic        wake;
    logic [1:0]  phase;
    logic        fetch_en;
    logic        pc_inc;
    logic        pc_load;
    logic [11:0] pc_target;
    logic [1:0]  alu_type;
    logic [3:0]  alu_op;
    logic        use_literal;
    logic        alu_start;
    logic        w_we;
    logic        f_we;
    logic [6:0]  f_addr;
    logic        push;
    logic        pop;
    logic        sleeping;

    int tests_run = 0;
    int tests_failed = 0;

    pic_cycle_controller #(
        .PC_WIDTH     (12),
        .RESET_VECTOR (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .alu_zero    (alu_zero),
        .f_bit       (f_bit),
        .stack_top   (stack_top),
        .wake        (wake),
        .phase       (phase),
        .fetch_en    (fetch_en),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .alu_type    (alu_type),
        .alu_op      (alu_op),
        .use_literal (use_literal),
        .alu_start   (alu_start),
        .w_we        (w_we),
        .f_we        (f_we),
        .f_addr      (f_addr),
        .push        (push),
        .pop         (pop),
        .sleeping    (sleeping)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one full instruction cycle starting in Q1, checking every phase at the negedge.
    task automatic exec(input string name, input logic [13:0] ins, input logic az,
                        input logic fb, input logic [11:0] st, input logic ew,
                        input logic ef, input logic epush, input logic epop,
                        input logic eload, input logic [11:0] etgt, input logic elit);
        instr     = ins;
        alu_zero  = az;
        f_bit     = fb;
        stack_top = st;
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            check({name, ".phase"},     32'(phase),     32'(p));
            check({name, ".pc_inc"},    32'(pc_inc),    32'(p == 0));
            check({name, ".alu_start"}, 32'(alu_start), 32'(p == 1));
            check({name, ".fetch_en"},  32'(fetch_en),  32'(p == 3));
            check({name, ".w_we"},      32'(w_we),      32'(p == 3 && ew));
            check({name, ".f_we"},      32'(f_we),      32'(p == 3 && ef));
            check({name, ".push"},      32'(push),      32'(p == 3 && epush));
            check({name, ".pop"},       32'(pop),       32'(p == 3 && epop));
            check({name, ".pc_load"},   32'(pc_load),   32'(p == 3 && eload));
            if (p == 0) begin
                check({name, ".use_literal"}, 32'(use_literal), 32'(elit));
                check({name, ".sleeping"},    32'(sleeping),    32'd0);
            end
            if (p == 3 && eload) begin
                check({name, ".pc_target"}, 32'(pc_target), 32'(etgt));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        instr     = 14'h0000;
        alu_zero  = 1'b0;
        f_bit     = 1'b0;
        stack_top = 12'h000;
        wake      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.phase",     32'(phase),     32'd0);
        check("rst.pc_inc",    32'(pc_inc),    32'd0);
        check("rst.fetch_en",  32'(fetch_en),  32'd0);
        check("rst.w_we",      32'(w_we),      32'd0);
        check("rst.pc_target", 32'(pc_target), 32'd0);
        check("rst.sleeping",  32'(sleeping),  32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        //    name        instr    az    fb    st       w     f     psh   pop   ld    tgt      lit
        exec("nop0",     14'h0000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
        exec("addlw",    14'h3E05, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
        exec("goto",     14'h2812, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h012, 1'b0);
        exec("goto_fl",  14'h3E05, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
        exec("decfsz_z", 14'h0B8C, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
        exec("dec_fl",   14'h0B8C, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
        exec("decfsz_n", 14'h0B8C, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
        exec("noskip",   14'h3E05, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
        exec("call",     14'h2100, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h100, 1'b0);
        exec("call_fl",  14'h3E05, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
        exec("return",   14'h0008, 1'b0, 1'b0, 12'h005, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h005, 1'b0);
        exec("ret_fl",   14'h008C, 1'b0, 1'b0, 12'h005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
        exec("movwf",    14'h008C, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
        exec("btfss",    14'h1C0C, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
        exec("btfss_fl", 14'h140C, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
        exec("bsf",      14'h140C, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
        exec("btfsc_nt", 14'h180C, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
        exec("retlw",    14'h3405, 1'b0, 1'b0, 12'h033, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h033, 1'b1);
        exec("retlw_fl", 14'h0100, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
        exec("clrw",     14'h0100, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
        exec("sleep",    14'h0063, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("slp.sleeping", 32'(sleeping), 32'd1);
            check("slp.phase",    32'(phase),    32'd0);
            check("slp.strobes",  32'({pc_inc, alu_start, fetch_en, w_we, f_we, push, pop, pc_load}), 32'd0);
        end
        wake = 1'b1;
        @(posedge clk);
        #1 wake = 1'b0;
        exec("wake_nop", 14'h0000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);

        // Abort a DECFSZ in Q3 and confirm its Q4 write never appears.
        instr    = 14'h0B8C;
        alu_zero = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rstq3.f_we", 32'(f_we), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rstq3.phase",    32'(phase),    32'd0);
        check("rstq3.f_we2",    32'(f_we),     32'd0);
        check("rstq3.fetch_en", 32'(fetch_en), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        exec("post_rst",  14'h3E05, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
        exec("post_rst2", 14'h3E05, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
